// File: rtl/tdm_pkg.sv
// Shared definitions for the mux-based TDM link: FSM state codes, default
// geometry, and the channel-index width helper used by both link ends.
package tdm_pkg;

    localparam int unsigned N_CH_DEF = 4;
    localparam int unsigned W_DEF    = 8;

    localparam logic [0:0] ST_HUNT   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // A single-channel link still needs a 1-bit index.
    function automatic int unsigned cw_of(input int unsigned n_ch);
        return (n_ch <= 1) ? 1 : $clog2(n_ch);
    endfunction

endpackage

// File: rtl/tdm_slot_buf.sv
// Shadow frame buffer with indexed writes, plus the publish register that
// presents a completed frame together with a one-cycle valid strobe.
module tdm_slot_buf
    import tdm_pkg::*;
#(
    parameter int unsigned N_CH = N_CH_DEF,
    parameter int unsigned W    = W_DEF,
    parameter int unsigned CW   = cw_of(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [CW-1:0]     wr_idx,
    input  logic [W-1:0]      wr_data,
    input  logic              publish,
    output logic [N_CH*W-1:0] out_data,
    output logic              out_valid
);

    logic [N_CH-1:0][W-1:0] shadow_q;
    logic [N_CH-1:0][W-1:0] merged;
    logic [N_CH-1:0][W-1:0] out_data_q;
    logic                   out_valid_q;

    // The final beat is not in the shadow yet at its accepting edge, so the
    // publish path takes it straight from the write port.
    always_comb begin
        merged = shadow_q;
        if (wr_en) begin
            merged[wr_idx] = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
        end else if (wr_en) begin
            shadow_q[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= publish;
            if (publish) begin
                out_data_q <= merged;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: rtl/tdm_demux.sv
// TDM receive end: locks onto the channel-0 sync flag, steers beats into
// their slots and publishes each complete frame via tdm_slot_buf.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int unsigned N_CH = N_CH_DEF,
    parameter int unsigned W    = W_DEF,
    parameter int unsigned CW   = cw_of(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sync,
    input  logic [W-1:0]      in_data,
    output logic [N_CH*W-1:0] out_data,
    output logic              out_valid,
    output logic              locked,
    output logic [CW-1:0]     ch_idx,
    output logic              sync_err
);

    localparam logic [CW-1:0] LAST_IDX = CW'(N_CH - 1);
    localparam logic [CW-1:0] ONE_IDX  = (N_CH > 1) ? CW'(1) : '0;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] idx_q, idx_d;
    logic          err_q, err_d;
    logic          wr_en;
    logic [CW-1:0] wr_idx;
    logic          publish;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = in_sync ? '0 : idx_q;
        publish = 1'b0;

        if (in_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (in_sync) begin
                        wr_en   = 1'b1;
                        state_d = ST_LOCKED;
                        idx_d   = ONE_IDX;
                        publish = (N_CH == 1);
                    end
                end
                ST_LOCKED: begin
                    if (in_sync) begin
                        // Early sync drops the partial frame; its slots get
                        // overwritten before the next publish.
                        err_d   = (idx_q != '0);
                        wr_en   = 1'b1;
                        idx_d   = ONE_IDX;
                        publish = (N_CH == 1);
                    end else if (idx_q == '0) begin
                        err_d   = 1'b1;
                        state_d = ST_HUNT;
                        idx_d   = '0;
                    end else begin
                        wr_en = 1'b1;
                        if (idx_q == LAST_IDX) begin
                            publish = 1'b1;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_HUNT;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    tdm_slot_buf #(
        .N_CH (N_CH),
        .W    (W),
        .CW   (CW)
    ) u_slot_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_data   (in_data),
        .publish   (publish),
        .out_data  (out_data),
        .out_valid (out_valid)
    );

    assign locked   = (state_q == ST_LOCKED);
    assign ch_idx   = idx_q;
    assign sync_err = err_q;

endmodule
